// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment front end.
// Holds the blank code, the conversion FSM state type and the decimal range helper.
package seg7_pkg;

    // Non-decimal code that the downstream decoder renders as all segments off.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter, one bit per cycle.
// The result and range flag are valid in the cycle that done is high.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow
);

    localparam int SCR_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = max_value(NUM_DIGITS);

    conv_state_t             state_reg;
    logic [BIN_W-1:0]        bin_reg;
    logic [SCR_W-1:0]        scratch_reg;
    logic [SCR_W-1:0]        scratch_adj;
    logic [CNT_W-1:0]        count_reg;
    logic                    ovf_pending_reg;
    logic [SCR_W+BIN_W-1:0]  shifted;
    logic [63:0]             bin_ext;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                          ? scratch_reg[4*gi +: 4] + 4'd3
                                          : scratch_reg[4*gi +: 4];
        end
    endgenerate

    // Carries out of the top nibble are dropped; the range flag covers that case.
    assign shifted  = {scratch_adj, bin_reg} << 1;
    assign bin_ext  = 64'(bin_in);
    assign bcd_out  = scratch_reg;
    assign overflow = ovf_pending_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            bin_reg         <= '0;
            scratch_reg     <= '0;
            count_reg       <= '0;
            ovf_pending_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        bin_reg         <= bin_in;
                        scratch_reg     <= '0;
                        count_reg       <= CNT_W'(BIN_W);
                        ovf_pending_reg <= (bin_ext > MAX_VAL);
                        busy            <= 1'b1;
                        state_reg       <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch_reg, bin_reg} <= shifted;
                    count_reg              <= count_reg - CNT_W'(1);
                    if (count_reg == CNT_W'(1)) begin
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Seven-segment front end: converts a binary value to BCD and time-multiplexes
// the digits onto a single nibble bus with a one-hot digit select.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int BIN_W       = 14,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [3:0]            bcd,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W  = $clog2(REFRESH_DIV);

    logic [DISP_W-1:0] conv_bcd;
    logic              conv_ovf;
    logic [DISP_W-1:0] display_reg;
    logic              overflow_reg;
    logic [DIV_W-1:0]  refresh_reg;
    logic [IDX_W-1:0]  scan_idx_reg;
    logic [3:0]        digit [NUM_DIGITS];
    logic              upper_zero;

    bin2bcd_seq #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (conv_bcd),
        .overflow (conv_ovf)
    );

    // Display only changes on the done cycle, so partial results never show.
    always_ff @(posedge clk) begin
        if (rst) begin
            display_reg  <= '0;
            overflow_reg <= 1'b0;
        end else if (done) begin
            display_reg  <= conv_bcd;
            overflow_reg <= conv_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_reg  <= '0;
            scan_idx_reg <= '0;
        end else if (refresh_reg == DIV_W'(REFRESH_DIV - 1)) begin
            refresh_reg  <= '0;
            scan_idx_reg <= (scan_idx_reg == IDX_W'(NUM_DIGITS - 1))
                          ? '0 : scan_idx_reg + IDX_W'(1);
        end else begin
            refresh_reg <= refresh_reg + DIV_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit[gi]     = display_reg[4*gi +: 4];
            assign digit_sel[gi] = (scan_idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign overflow = overflow_reg;

    // Select and data both come straight from registers, so they switch together.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(scan_idx_reg) && digit[i] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        bcd = digit[scan_idx_reg];
        if (overflow_reg || (BLANK_LZ != 0 && scan_idx_reg != '0 && upper_zero)) begin
            bcd = BLANK_CODE;
        end
    end

endmodule
